// File: rtl/ghash_accumulator.sv
// GHASH accumulator: holds hash subkey H and running value Y, absorbs one
// 128-bit block every two cycles as Y <= (Y ^ X) * H in GF(2^128), and
// presents the final Y as a tag when the last block of a message completes.
//
// state  | meaning
// NO_KEY | no subkey loaded since reset; only H may be accepted
// IDLE   | ready for next block (or H reload when no message is open)
// MULT   | multiplier result for op_q * h_q is written into acc_q
// OUT    | tag presented on m_tag until m_ready, then accumulator clears
module ghash_accumulator (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         h_valid,
  input  logic [127:0] h_key,
  output logic         h_ready,
  input  logic         s_valid,
  input  logic [127:0] s_data,
  input  logic         s_last,
  output logic         s_ready,
  output logic         m_valid,
  output logic [127:0] m_tag,
  input  logic         m_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    NO_KEY = 2'd0,
    IDLE   = 2'd1,
    MULT   = 2'd2,
    OUT    = 2'd3
  } state_t;

  // GCM reflected bit order: x^0 lives in bit 127, so R = x^7+x^2+x+1 is 0xE1 at the top.
  localparam logic [127:0] GF_R = {8'hE1, 120'h0};

  state_t       state_q, state_d;
  logic [127:0] h_q;
  logic [127:0] acc_q;
  logic [127:0] op_q;
  logic         last_q;
  logic         in_msg_q;
  logic [127:0] prod;
  logic         h_fire;
  logic         s_fire;

  assign h_fire = h_valid & h_ready;
  assign s_fire = s_valid & s_ready;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= NO_KEY;
    else        state_q <= state_d;
  end

  // Next-state logic; a key load in IDLE takes priority over a block.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NO_KEY: if (h_fire) state_d = IDLE;
      IDLE:   if (!h_fire && s_fire) state_d = MULT;
      MULT:   state_d = last_q ? OUT : IDLE;
      OUT:    if (m_ready) state_d = IDLE;
      default: state_d = NO_KEY;
    endcase
  end

  // Handshake outputs depend only on state, in_msg and h_valid.
  always_comb begin
    h_ready = 1'b0;
    s_ready = 1'b0;
    m_valid = 1'b0;
    unique case (state_q)
      NO_KEY: h_ready = 1'b1;
      IDLE: begin
        h_ready = !in_msg_q;
        s_ready = !(h_valid && !in_msg_q);
      end
      OUT:    m_valid = 1'b1;
      default: ;
    endcase
  end

  assign m_tag = acc_q;
  assign busy  = in_msg_q;

  // Shift-and-add GF(2^128) multiply of op_q by h_q, single cycle.
  always_comb begin
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = h_q;
    for (int i = 0; i < 128; i++) begin
      if (op_q[127-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ GF_R) : (v >> 1);
    end
    prod = z;
  end

  // Datapath registers: key, block operand, accumulator and message flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q      <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      last_q   <= 1'b0;
      in_msg_q <= 1'b0;
    end else begin
      if (h_fire) h_q <= h_key;
      if (state_q == IDLE && s_fire && !h_fire) begin
        op_q     <= acc_q ^ s_data;
        last_q   <= s_last;
        in_msg_q <= 1'b1;
      end
      if (state_q == MULT) acc_q <= prod;
      if (state_q == OUT && m_ready) begin
        acc_q    <= '0;
        in_msg_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ghash_accumulator.sv
// Bench for ghash_accumulator: directed reset/identity/reduction/backpressure/
// collision cases, then randomized messages checked against a polynomial
// GHASH model (bit-reverse, carry-less multiply, reduce, reverse back).
module tb_ghash_accumulator;

  localparam logic [127:0] ONE = {1'b1, 127'h0};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         h_valid;
  logic [127:0] h_key;
  logic         h_ready;
  logic         s_valid;
  logic [127:0] s_data;
  logic         s_last;
  logic         s_ready;
  logic         m_valid;
  logic [127:0] m_tag;
  logic         m_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;

  ghash_accumulator dut (
    .clk(clk), .rst_n(rst_n),
    .h_valid(h_valid), .h_key(h_key), .h_ready(h_ready),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_tag(m_tag), .m_ready(m_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rev(input logic [127:0] a);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = a[127-i];
    return r;
  endfunction

  // Product in ordinary polynomial form, reduced by x^128 + x^7 + x^2 + x + 1.
  function automatic logic [127:0] gmul(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] p;
    logic [127:0] pa, pb;
    pa = rev(a);
    pb = rev(b);
    p  = '0;
    for (int i = 0; i < 128; i++)
      if (pb[i]) p = p ^ ({128'h0, pa} << i);
    for (int i = 254; i >= 128; i--)
      if (p[i]) begin
        p[i]       = 1'b0;
        p[i-121]   = ~p[i-121];
        p[i-126]   = ~p[i-126];
        p[i-127]   = ~p[i-127];
        p[i-128]   = ~p[i-128];
      end
    return rev(p[127:0]);
  endfunction

  task automatic load_key(input logic [127:0] k);
    int n;
    @(negedge clk);
    h_valid = 1'b1;
    h_key   = k;
    #1;
    n = 0;
    while (!h_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("key_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    h_valid = 1'b0;
  endtask

  // Returns right after the accepting edge, s_valid still asserted.
  task automatic send_blk(input logic [127:0] d, input logic last);
    int n;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    #1;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("blk_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic take_tag();
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] d1, d2, hk, expv, tag0;
    logic [127:0] blk[16];
    int nblk, idx, cyc;
    bit got;

    rst_n = 1'b0; h_valid = 1'b0; h_key = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;

    // Reset and key load
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_h_ready", h_ready, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_tag", m_tag, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    load_key(ONE);
    #1;
    chk("key_s_ready", s_ready, 1);

    // Identity H: tag is XOR of blocks; check two-edge latency
    d1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    send_blk(d1, 1'b0);
    send_blk({128{1'b1}}, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    chk("lat_mult_m_valid", m_valid, 0);
    @(negedge clk);
    #1;
    chk("lat_out_m_valid", m_valid, 1);
    chk("ident_tag", m_tag, 128'hFEDCBA9876543210FEDCBA9876543210);
    chk("ident_busy", busy, 1);
    take_tag();
    #1;
    chk("ident_done_m_valid", m_valid, 0);
    chk("ident_done_busy", busy, 0);

    // Reduction x * x^127 = R, then backpressure
    load_key(128'h1);
    send_blk({2'b01, 126'h0}, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("red_tag", m_tag, {8'hE1, 120'h0});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("bp_tag", m_tag, {8'hE1, 120'h0});
      chk("bp_ready", {h_ready, s_ready, m_valid}, 3'b001);
    end
    take_tag();
    load_key(ONE);
    send_blk(ONE, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("clear_tag", m_tag, ONE);
    take_tag();

    // Key/stream collision, and h_valid ignored mid-message
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    h_valid = 1'b1; h_key = ONE;
    s_valid = 1'b1; s_data = d1; s_last = 1'b0;
    #1;
    chk("coll_s_ready", s_ready, 0);
    chk("coll_h_ready", h_ready, 1);
    @(posedge clk);
    @(negedge clk);
    h_valid = 1'b0;
    #1;
    chk("coll_next_s_ready", s_ready, 1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    h_valid = 1'b1; h_key = {$urandom, $urandom, $urandom, $urandom} | 128'h2;
    #1;
    chk("msg_h_ready", h_ready, 0);
    send_blk(d2, 1'b1);
    @(negedge clk);
    s_valid = 1'b0; h_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("msg_key_kept_tag", m_tag, d1 ^ d2);
    take_tag();

    // Randomized messages with gaps and backpressure
    hk = ONE;
    for (int m = 0; m < 200; m++) begin
      if (m == 0 || $urandom_range(3, 0) == 0) begin
        hk = {$urandom, $urandom, $urandom, $urandom};
        load_key(hk);
      end
      nblk = $urandom_range(16, 1);
      expv = '0;
      for (int b = 0; b < nblk; b++) begin
        blk[b] = {$urandom, $urandom, $urandom, $urandom};
        expv = gmul(expv ^ blk[b], hk);
      end
      idx = 0;
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 400) begin
        @(negedge clk);
        s_valid = (idx < nblk) && ($urandom_range(3, 0) != 0);
        s_data  = blk[idx < nblk ? idx : 0];
        s_last  = (idx == nblk - 1);
        m_ready = ($urandom_range(2, 0) != 0);
        #1;
        chk("rnd_h_ready_busy", h_ready & busy, 0);
        if (s_valid && s_ready) idx++;
        if (m_valid && m_ready) begin
          chk("rnd_tag", m_tag, expv);
          chk("rnd_blocks", idx, nblk);
          got = 1'b1;
        end
        @(posedge clk);
        cyc++;
      end
      if (!got) chk("rnd_timeout", 0, 1);
      @(negedge clk);
      s_valid = 1'b0; m_ready = 1'b0;
    end

    // Reset pulse mid-message drops everything
    send_blk({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    send_blk({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("mrst_outputs", {h_ready, s_ready, m_valid, busy}, 4'b1000);
    chk("mrst_tag", m_tag, 0);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (m_valid) got = 1'b1;
    end
    chk("mrst_no_tag", got, 0);
    chk("mrst_no_key", s_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
